operand_skew_feeder: RTL and testbench

//  Upstream feeder for the 4-bit carry-registered ripple adder (carry moves one slice per clock).
//  - Buffers operand pairs (A,B,CIN,TAG) in a small FIFO under valid/ready.
//  - Issues at most one op per cycle, skewing bit k by k cycles so each slice sees its operand bits
//    in the same cycle as that op's registered carry.
//  - Tracks in-flight ops; pulses DONE with the TAG in the cycle SUM[W-1]/COUT of that op is valid.

---
 rtl/operand_skew_feeder_pkg.sv | 28 ++
 rtl/operand_skew_feeder_sync_fifo.sv | 53 +++++
 rtl/operand_skew_feeder.sv | 102 ++++++++++
 tb/tb_operand_skew_feeder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/operand_skew_feeder_pkg.sv
// operand_skew_feeder_pkg: shared defaults, op record and width helpers for the skew feeder
package operand_skew_feeder_pkg;
    localparam int W_DEF     = 4;
    localparam int TAGW_DEF  = 2;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic [W_DEF-1:0]    a;
        logic [W_DEF-1:0]    b;
        logic                cin;
        logic [TAGW_DEF-1:0] tag;
    } op_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int op_w(input int w, input int tagw);
        return 2 * w + 1 + tagw;
    endfunction

    // Slice k keeps bits [w-1:k] of its op, so the triangle packs slices back to back
    function automatic int tri_off(input int w, input int k);
        return k * w - k * (k - 1) / 2;
    endfunction
endpackage

// File: rtl/operand_skew_feeder_sync_fifo.sv
// operand_skew_feeder_sync_fifo: DEPTH-entry FIFO with registered count, full and empty
module operand_skew_feeder_sync_fifo
    import operand_skew_feeder_pkg::*;
#(
    parameter int DW    = 11,
    parameter int DEPTH = 4
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, empty_q;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;
    assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    assign rdata_o = mem_q[rp_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge CK) begin
        if (RST) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wp_q    <= do_push ? wp_q + AW'(1) : wp_q;
            rp_q    <= do_pop ? rp_q + AW'(1) : rp_q;
            cnt_q   <= cnt_d;
            full_q  <= cnt_d == CW'(DEPTH);
            empty_q <= cnt_d == '0;
        end
    end

    always_ff @(posedge CK) begin
        if (do_push) mem_q[wp_q] <= wdata_i;
    end
endmodule

// File: rtl/operand_skew_feeder.sv
// operand_skew_feeder: buffers operand pairs and feeds them bit-skewed into a carry-registered ripple adder
module operand_skew_feeder
    import operand_skew_feeder_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAGW  = TAGW_DEF
) (
    input  logic                     CK,
    input  logic                     RST,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [W-1:0]             in_a_i,
    input  logic [W-1:0]             in_b_i,
    input  logic                     in_cin_i,
    input  logic [TAGW-1:0]          in_tag_i,
    input  logic                     issue_en_i,
    output logic [W-1:0]             a_sk_o,
    output logic [W-1:0]             b_sk_o,
    output logic                     cin_sk_o,
    output logic [W-1:0]             slice_vld_o,
    output logic                     done_o,
    output logic [TAGW-1:0]          done_tag_o,
    output logic [clog2(W+1)-1:0]    in_flight_o
);
    localparam int OW  = op_w(W, TAGW);
    localparam int FW  = clog2(W + 1);
    localparam int TRI = tri_off(W, W);

    logic            full, empty, pop;
    logic [OW-1:0]   head;
    logic [W-1:0]    hd_a, hd_b;
    logic            hd_cin;
    logic [TAGW-1:0] hd_tag;

    operand_skew_feeder_sync_fifo #(.DW(OW), .DEPTH(DEPTH)) u_fifo (
        .CK      (CK),
        .RST     (RST),
        .push_i  (in_valid_i),
        .wdata_i ({in_a_i, in_b_i, in_cin_i, in_tag_i}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign pop = issue_en_i && !empty;
    assign {hd_a, hd_b, hd_cin, hd_tag} = head;
    assign in_ready_o = !full;

    logic [TRI-1:0]    a_tri_q, a_tri_d, b_tri_q, b_tri_d;
    logic              cin_q, cin_d;
    logic [W-1:0]      vld_q, vld_d;
    logic [W*TAGW-1:0] tag_q, tag_d;
    logic [FW-1:0]     flight_q, flight_d;

    // Bubbles load zero operands so a slice with no op never generates a carry
    for (genvar k = 0; k < W; k++) begin : g_slice
        if (k == 0) begin : g_issue
            assign a_tri_d[W-1:0] = pop ? hd_a : '0;
            assign b_tri_d[W-1:0] = pop ? hd_b : '0;
        end else begin : g_skew
            assign a_tri_d[tri_off(W, k) +: W-k] = a_tri_q[tri_off(W, k-1)+1 +: W-k];
            assign b_tri_d[tri_off(W, k) +: W-k] = b_tri_q[tri_off(W, k-1)+1 +: W-k];
        end
        assign a_sk_o[k] = a_tri_q[tri_off(W, k)];
        assign b_sk_o[k] = b_tri_q[tri_off(W, k)];
    end

    assign cin_d = pop && hd_cin;
    assign vld_d = {vld_q[W-2:0], pop};
    assign tag_d = {tag_q[(W-1)*TAGW-1:0], pop ? hd_tag : {TAGW{1'b0}}};

    always_comb begin
        flight_d = '0;
        for (int k = 0; k < W; k++) flight_d = flight_d + FW'(vld_d[k]);
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            a_tri_q  <= '0;
            b_tri_q  <= '0;
            cin_q    <= 1'b0;
            vld_q    <= '0;
            tag_q    <= '0;
            flight_q <= '0;
        end else begin
            a_tri_q  <= a_tri_d;
            b_tri_q  <= b_tri_d;
            cin_q    <= cin_d;
            vld_q    <= vld_d;
            tag_q    <= tag_d;
            flight_q <= flight_d;
        end
    end

    assign cin_sk_o    = cin_q;
    assign slice_vld_o = vld_q;
    assign done_o      = vld_q[W-1];
    assign done_tag_o  = tag_q[W*TAGW-1 -: TAGW];
    assign in_flight_o = flight_q;
endmodule

// File: tb/tb_operand_skew_feeder.sv
// tb_operand_skew_feeder: drives the feeder into a behavioural carry-registered adder and scores results
module tb_operand_skew_feeder;
    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int TAGW  = 2;

    logic            CK = 1'b0;
    logic            RST = 1'b1;
    logic            in_valid = 1'b0, in_ready, in_cin = 1'b0, issue_en = 1'b0;
    logic [W-1:0]    in_a = '0, in_b = '0;
    logic [TAGW-1:0] in_tag = '0;
    logic [W-1:0]    a_sk, b_sk, slice_vld;
    logic            cin_sk, done;
    logic [TAGW-1:0] done_tag;
    logic [2:0]      in_flight;

    operand_skew_feeder #(.W(W), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .CK          (CK),
        .RST         (RST),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_cin_i    (in_cin),
        .in_tag_i    (in_tag),
        .issue_en_i  (issue_en),
        .a_sk_o      (a_sk),
        .b_sk_o      (b_sk),
        .cin_sk_o    (cin_sk),
        .slice_vld_o (slice_vld),
        .done_o      (done),
        .done_tag_o  (done_tag),
        .in_flight_o (in_flight)
    );

    always #5 CK = ~CK;

    typedef struct packed {
        logic            cout;
        logic [W-1:0]    sum;
        logic [TAGW-1:0] tag;
    } res_t;

    int   total = 0, bad = 0;
    int   edge_n = 0, nbuf = 0;
    int   fly[$];
    res_t exp_q[$];
    logic [W-1:0] c_q = '0;
    logic [W-1:0] ps[W];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    // Ripple adder with one carry register per slice boundary; slice 0 takes CIN_SK directly
    function automatic void eval(output logic [W-1:0] s, output logic [W-1:0] co);
        logic c;
        for (int k = 0; k < W; k++) begin
            c = (k == 0) ? cin_sk : c_q[k];
            s[k] = a_sk[k] ^ b_sk[k] ^ c;
            co[k] = (a_sk[k] & b_sk[k]) | (c & (a_sk[k] ^ b_sk[k]));
        end
    endfunction

    initial begin
        logic [W-1:0] s, co, mask, sum;
        logic         exp_done, rdy;
        res_t         r;
        for (int k = 0; k < W; k++) ps[k] = '0;
        forever begin
            @(posedge CK);
            edge_n++;
            eval(s, co);
            if (RST) begin
                c_q = '0;
                for (int k = 0; k < W; k++) ps[k] = '0;
                nbuf = 0;
                fly.delete();
                exp_q.delete();
            end else begin
                for (int k = W - 1; k >= 1; k--) begin
                    ps[k] = ((k == 1) ? '0 : ps[k-1]) | (W'(s[k-1]) << (k - 1));
                    c_q[k] = co[k-1];
                end
                rdy = nbuf < DEPTH;
                if (issue_en && nbuf > 0) begin
                    nbuf--;
                    fly.push_back(edge_n + W - 1);
                end
                if (in_valid && rdy) begin
                    nbuf++;
                    r.tag = in_tag;
                    {r.cout, r.sum} = (W+1)'(in_a) + (W+1)'(in_b) + (W+1)'(in_cin);
                    exp_q.push_back(r);
                end
            end
            #1;
            if (RST) begin
                chk("rst_a_sk", a_sk, 0);
                chk("rst_b_sk", b_sk, 0);
                chk("rst_cin_sk", cin_sk, 0);
                chk("rst_slice_vld", slice_vld, 0);
                chk("rst_done", done, 0);
                chk("rst_done_tag", done_tag, 0);
                chk("rst_in_flight", in_flight, 0);
            end else begin
                exp_done = fly.size() > 0 && fly[0] == edge_n;
                mask = '0;
                foreach (fly[i]) mask[W - 1 - (fly[i] - edge_n)] = 1'b1;
                chk("slice_vld", slice_vld, mask);
                chk("done", done, exp_done);
                chk("in_flight", in_flight, fly.size());
                if (exp_done) void'(fly.pop_front());
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("done_without_op", 1, 0);
                    end else begin
                        r = exp_q.pop_front();
                        eval(s, co);
                        sum = ps[W-1] | (W'(s[W-1]) << (W - 1));
                        chk("sum", sum, r.sum);
                        chk("cout", co[W-1], r.cout);
                        chk("done_tag", done_tag, r.tag);
                    end
                end
            end
            chk("in_ready", in_ready, nbuf < DEPTH);
        end
    end

    task automatic cyc(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [TAGW-1:0] t, input logic ie, output logic acc);
        @(negedge CK);
        in_valid = v;
        in_a = a;
        in_b = b;
        in_cin = c;
        in_tag = t;
        issue_en = ie;
        acc = v && in_ready;
    endtask

    task automatic put(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [TAGW-1:0] t, input logic ie);
        logic acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) cyc(1'b1, a, b, c, t, ie, acc);
        chk("put_accept", acc, 1);
    endtask

    task automatic idle(input int n, input logic ie);
        logic acc;
        repeat (n) cyc(1'b0, '0, '0, 1'b0, '0, ie, acc);
    endtask

    initial begin
        logic [W-1:0] pa[8] = '{4'hF, 4'h3, 4'hA, 4'h0, 4'hF, 4'h8, 4'h5, 4'hC};
        logic [W-1:0] pb[8] = '{4'h1, 4'h4, 4'h6, 4'h0, 4'hF, 4'h8, 4'hB, 4'h3};
        logic         pc[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic         acc, have, v, ie;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [TAGW-1:0] rt;
        int           acc_n;
        repeat (2) @(posedge CK);
        @(negedge CK);
        RST = 1'b0;
        // single op 7+9
        put(4'h7, 4'h9, 1'b0, 2'd1, 1'b1);
        idle(6, 1'b1);
        // back-to-back stream
        for (int i = 0; i < 8; i++) put(pa[i], pb[i], pc[i], TAGW'(i), 1'b1);
        idle(6, 1'b1);
        // fill while throttled, fifth offer must be refused
        for (int i = 0; i < 4; i++) put(4'(i * 5 + 3), 4'(i * 7 + 9), i[0], TAGW'(i), 1'b0);
        cyc(1'b1, 4'hE, 4'hE, 1'b1, 2'd3, 1'b0, acc);
        chk("fifth_rejected", acc, 0);
        cyc(1'b1, 4'hE, 4'hE, 1'b1, 2'd3, 1'b0, acc);
        chk("fifth_rejected_hold", acc, 0);
        idle(8, 1'b1);
        // carry-heavy ops issued with bubbles between them
        for (int i = 0; i < 4; i++) put(4'hF, 4'h1, i[0], TAGW'(i), 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, '0, '0, 1'b0, '0, i[0] == 1'b0, acc);
        idle(6, 1'b1);
        // reset with three in flight and two buffered
        put(4'h9, 4'h9, 1'b1, 2'd0, 1'b0);
        put(4'hB, 4'h7, 1'b0, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++) put(4'hF, 4'hF, 1'b1, TAGW'(i + 2), 1'b1);
        @(negedge CK);
        in_valid = 1'b0;
        issue_en = 1'b0;
        RST = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        idle(8, 1'b1);
        // random traffic
        acc_n = 0;
        have = 1'b0;
        for (int i = 0; i < 20000 && acc_n < 1000; i++) begin
            if (!have) begin
                ra = W'($urandom);
                rb = W'($urandom);
                rc = 1'($urandom);
                rt = TAGW'(acc_n);
                have = 1'b1;
            end
            v = $urandom_range(0, 3) != 0;
            ie = $urandom_range(0, 3) != 0;
            cyc(v, ra, rb, rc, rt, ie, acc);
            if (acc) begin
                acc_n++;
                have = 1'b0;
            end
        end
        chk("rand_accepted", acc_n, 1000);
        for (int i = 0; i < 50 && (exp_q.size() != 0 || fly.size() != 0); i++) idle(1, 1'b1);
        chk("drain_left", exp_q.size(), 0);
        idle(2, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
